// File: rtl/idx_update_unit_if.sv
// Record/variation/result bundle for idx_update_unit.
// The master drives records and variations; the slave (the update engine) returns results.
interface idx_update_unit_if #(
  parameter int N_IDX = 4,
  parameter int IDX_W = 12,
  parameter int VAR_W = 12
);
  logic                   in_valid;
  logic [N_IDX*IDX_W-1:0] in_idx;
  logic [3:0]             in_m;
  logic [4:0]             in_d;
  logic [3:0]             today_m;
  logic [4:0]             today_d;
  logic                   var_valid;
  logic [VAR_W-1:0]       var_in;
  logic                   busy;
  logic                   out_valid;
  logic [N_IDX*IDX_W-1:0] out_idx;
  logic [3:0]             out_m;
  logic [4:0]             out_d;
  logic [1:0]             warn;

  modport master (
    output in_valid, in_idx, in_m, in_d, today_m, today_d, var_valid, var_in,
    input  busy, out_valid, out_idx, out_m, out_d, warn
  );

  modport slave (
    input  in_valid, in_idx, in_m, in_d, today_m, today_d, var_valid, var_in,
    output busy, out_valid, out_idx, out_m, out_d, warn
  );
endinterface

// File: rtl/idx_update_unit.sv
// Saturating per-channel index update engine with date stamping and Warn_Msg status.
// Optional macro IDX_UPD_HOLD_ON_WARN_EN: on saturation, return the original record unchanged.
module idx_update_unit #(
  parameter int N_IDX = 4,
  parameter int IDX_W = 12,
  parameter int VAR_W = 12
) (
  input logic              clk,
  input logic              rst,
  idx_update_unit_if.slave bus
);

  localparam int MAX_W = (IDX_W > VAR_W) ? IDX_W : VAR_W;
  localparam int SUM_W = MAX_W + 2;
  localparam int K_W   = (N_IDX > 1) ? $clog2(N_IDX) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_IDX - 1);
  localparam logic signed [SUM_W-1:0] IDX_MAX = {{(SUM_W-IDX_W){1'b0}}, {IDX_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  state_t           state;
  logic [K_W-1:0]   k;
  logic             sat_flag;
  logic [IDX_W-1:0] work_idx [N_IDX];
  logic [3:0]       today_m_q;
  logic [4:0]       today_d_q;
`ifdef IDX_UPD_HOLD_ON_WARN_EN
  logic [N_IDX*IDX_W-1:0] orig_idx;
  logic [3:0]             orig_m;
  logic [4:0]             orig_d;
`endif

  logic [IDX_W-1:0]        cur_idx;
  logic signed [SUM_W-1:0] sum;
  logic [IDX_W-1:0]        clamped;
  logic                    sat_hit;
  logic                    flag_final;
  logic [N_IDX*IDX_W-1:0]  next_packed;

  // The sum is wide enough that neither overflow nor underflow can wrap before clamping.
  always_comb begin
    cur_idx     = work_idx[k];
    sum         = $signed({{(SUM_W-IDX_W){1'b0}}, cur_idx})
                + $signed({{(SUM_W-VAR_W){bus.var_in[VAR_W-1]}}, bus.var_in});
    clamped     = sum[IDX_W-1:0];
    sat_hit     = 1'b0;
    if (sum[SUM_W-1]) begin
      clamped = '0;
      sat_hit = 1'b1;
    end else if (sum > IDX_MAX) begin
      clamped = '1;
      sat_hit = 1'b1;
    end
    flag_final  = sat_flag | sat_hit;
    next_packed = '0;
    for (int c = 0; c < N_IDX; c++) begin
      next_packed[(N_IDX-1-c)*IDX_W +: IDX_W] = (K_W'(c) == k) ? clamped : work_idx[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      k             <= '0;
      sat_flag      <= 1'b0;
      today_m_q     <= '0;
      today_d_q     <= '0;
      for (int c = 0; c < N_IDX; c++) work_idx[c] <= '0;
`ifdef IDX_UPD_HOLD_ON_WARN_EN
      orig_idx      <= '0;
      orig_m        <= '0;
      orig_d        <= '0;
`endif
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_m     <= '0;
      bus.out_d     <= '0;
      bus.warn      <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          bus.out_valid <= 1'b0;
          if (bus.in_valid) begin
            for (int c = 0; c < N_IDX; c++) begin
              work_idx[c] <= bus.in_idx[(N_IDX-1-c)*IDX_W +: IDX_W];
            end
`ifdef IDX_UPD_HOLD_ON_WARN_EN
            orig_idx <= bus.in_idx;
            orig_m   <= bus.in_m;
            orig_d   <= bus.in_d;
`endif
            today_m_q <= bus.today_m;
            today_d_q <= bus.today_d;
            k         <= '0;
            sat_flag  <= 1'b0;
            bus.busy  <= 1'b1;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (bus.var_valid) begin
            work_idx[k] <= clamped;
            sat_flag    <= flag_final;
            if (k == K_LAST) begin
              k             <= '0;
              state         <= OUT;
              bus.out_valid <= 1'b1;
              bus.warn      <= flag_final ? 2'b11 : 2'b00;
`ifdef IDX_UPD_HOLD_ON_WARN_EN
              if (flag_final) begin
                bus.out_idx <= orig_idx;
                bus.out_m   <= orig_m;
                bus.out_d   <= orig_d;
              end else begin
                bus.out_idx <= next_packed;
                bus.out_m   <= today_m_q;
                bus.out_d   <= today_d_q;
              end
`else
              bus.out_idx <= next_packed;
              bus.out_m   <= today_m_q;
              bus.out_d   <= today_d_q;
`endif
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        OUT: begin
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
